pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 31 +++
 rtl/pipeline_ctrl_hazard_detect.sv | 65 ++++++
 rtl/pipeline_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM encoding, forward selects
// and the stage-control bundle driven onto the pipeline registers.
package pipeline_ctrl_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } ctrl_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idexe_en;
        logic exemem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idexe_flush;
    } stage_ctl_t;

    // Canned stage-control patterns, one per controller action
    localparam stage_ctl_t CTL_RESET    = 7'b00000_11;
    localparam stage_ctl_t CTL_FREEZE   = 7'b00000_00;
    localparam stage_ctl_t CTL_BRANCH   = 7'b11111_11;
    localparam stage_ctl_t CTL_LOAD_USE = 7'b00111_01;
    localparam stage_ctl_t CTL_NORMAL   = 7'b11111_00;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use hazard detection and EXE operand forward selection.
module hazard_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_W  = 5,
    parameter int unsigned FWD_EN = 1
) (
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] ex_src1,
    input  logic [REG_W-1:0] ex_src2,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_wb_en,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic [REG_W-1:0] wb_dest,
    input  logic             wb_wb_en,
    output logic             hz_ld,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    // True when dest is a real register read by the instruction in ID
    function automatic logic id_reads(input logic [REG_W-1:0] dest,
                                      input logic [REG_W-1:0] s1,
                                      input logic [REG_W-1:0] s2,
                                      input logic             two);
        return (dest != '0) && ((dest == s1) || (two && (dest == s2)));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                           input logic [REG_W-1:0] m_dest,
                                           input logic             m_wb,
                                           input logic [REG_W-1:0] w_dest,
                                           input logic             w_wb);
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != '0) begin
            if (m_wb && (m_dest == src)) begin
                sel = FWD_MEM;
            end else if (w_wb && (w_dest == src)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    always_comb begin
        hz_ld = ex_mem_read & ex_wb_en & id_reads(ex_dest, id_src1, id_src2, id_two_src);
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (FWD_EN != 0) begin
            fwd_a = fwd_sel(ex_src1, mem_dest, mem_wb_en, wb_dest, wb_wb_en);
            fwd_b = fwd_sel(ex_src2, mem_dest, mem_wb_en, wb_dest, wb_wb_en);
        end else begin
            // Without bypass paths every in-flight producer is a hazard
            hz_ld = hz_ld
                  | (ex_wb_en  & id_reads(ex_dest,  id_src1, id_src2, id_two_src))
                  | (mem_wb_en & id_reads(mem_dest, id_src1, id_src2, id_two_src));
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: stage enables/flushes, forwarding selects,
// memory-wait FSM and saturating performance counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned LEN    = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned FWD_EN = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] ex_src1,
    input  logic [REG_W-1:0] ex_src2,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_wb_en,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic [REG_W-1:0] wb_dest,
    input  logic             wb_wb_en,
    input  logic             br_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idexe_en,
    output logic             exemem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idexe_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    if (LEN == 0 || REG_W == 0 || CNT_W == 0) begin : g_param_check
        $error("pipeline_ctrl: LEN, REG_W and CNT_W must be non-zero");
    end

    ctrl_state_e      state_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic [CNT_W-1:0] wait_q;

    logic             hz_ld;
    logic [1:0]       hd_fwd_a;
    logic [1:0]       hd_fwd_b;
    logic             mem_stall;
    logic             do_stall;
    logic             do_flush;
    stage_ctl_t       ctl;

    hazard_detect #(
        .REG_W  (REG_W),
        .FWD_EN (FWD_EN)
    ) u_hazard_detect (
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_two_src  (id_two_src),
        .ex_src1     (ex_src1),
        .ex_src2     (ex_src2),
        .ex_dest     (ex_dest),
        .ex_wb_en    (ex_wb_en),
        .ex_mem_read (ex_mem_read),
        .mem_dest    (mem_dest),
        .mem_wb_en   (mem_wb_en),
        .wb_dest     (wb_dest),
        .wb_wb_en    (wb_wb_en),
        .hz_ld       (hz_ld),
        .fwd_a       (hd_fwd_a),
        .fwd_b       (hd_fwd_b)
    );

    assign mem_stall = mem_req & ~mem_ready;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic             inc);
        return (inc && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;
    endfunction

    // Action priority: reset > memory freeze > taken branch > load-use > run
    always_comb begin
        ctl      = CTL_NORMAL;
        do_stall = 1'b0;
        do_flush = 1'b0;
        if (reset) begin
            ctl = CTL_RESET;
        end else if (mem_stall) begin
            ctl = CTL_FREEZE;
        end else if (br_taken) begin
            ctl      = CTL_BRANCH;
            do_flush = 1'b1;
        end else if (hz_ld) begin
            ctl      = CTL_LOAD_USE;
            do_stall = 1'b1;
        end
    end

    // MEM_WAIT is only reported while the stall persists; the release cycle reads as RUN
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
            stall_q <= '0;
            flush_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= mem_stall ? ST_MEM_WAIT : ST_RUN;
            stall_q <= sat_inc(stall_q, do_stall);
            flush_q <= sat_inc(flush_q, do_flush);
            wait_q  <= sat_inc(wait_q, mem_stall);
        end
    end

    assign pc_en       = ctl.pc_en;
    assign ifid_en     = ctl.ifid_en;
    assign idexe_en    = ctl.idexe_en;
    assign exemem_en   = ctl.exemem_en;
    assign memwb_en    = ctl.memwb_en;
    assign ifid_flush  = ctl.ifid_flush;
    assign idexe_flush = ctl.idexe_flush;

    assign fwd_a     = reset ? FWD_RF : hd_fwd_a;
    assign fwd_b     = reset ? FWD_RF : hd_fwd_b;
    assign state     = ~reset & (state_q == ST_MEM_WAIT) & mem_stall;
    assign stall_cnt = reset ? '0 : stall_q;
    assign flush_cnt = reset ? '0 : flush_q;
    assign wait_cnt  = reset ? '0 : wait_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: forwarding and non-forwarding instances
// share stimulus and are checked against a behavioural reference model.
module tb_pipeline_ctrl;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned CNT_W   = 16;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [REG_W-1:0] id_src1, id_src2, ex_src1, ex_src2, ex_dest, mem_dest, wb_dest;
    logic id_two_src, ex_wb_en, ex_mem_read, mem_wb_en, mem_req, mem_ready, wb_wb_en, br_taken;

    logic pc_en_f, ifid_en_f, idexe_en_f, exemem_en_f, memwb_en_f, ifid_flush_f, idexe_flush_f, state_f;
    logic pc_en_n, ifid_en_n, idexe_en_n, exemem_en_n, memwb_en_n, ifid_flush_n, idexe_flush_n, state_n;
    logic [1:0] fwd_a_f, fwd_b_f, fwd_a_n, fwd_b_n;
    logic [CNT_W-1:0] stall_cnt_f, flush_cnt_f, wait_cnt_f, stall_cnt_n, flush_cnt_n, wait_cnt_n;

    typedef struct packed {
        logic [4:0]       en;   // pc, ifid, idexe, exemem, memwb
        logic [1:0]       fl;   // ifid_flush, idexe_flush
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic             st;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
        logic [CNT_W-1:0] wc;
    } obs_t;

    typedef struct packed {
        obs_t e_fwd;
        obs_t e_nofwd;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_item;
    obs_t obs_f, obs_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state, index 1 = forwarding build, 0 = stall-only build
    bit m_wait[2];
    int m_sc[2], m_fc[2], m_wc[2];

    always #5 clock = ~clock;

    pipeline_ctrl #(.LEN(32), .REG_W(REG_W), .FWD_EN(1), .CNT_W(CNT_W)) u_dut (
        .clock(clock), .reset(reset),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_dest(ex_dest),
        .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .br_taken(br_taken),
        .pc_en(pc_en_f), .ifid_en(ifid_en_f), .idexe_en(idexe_en_f),
        .exemem_en(exemem_en_f), .memwb_en(memwb_en_f),
        .ifid_flush(ifid_flush_f), .idexe_flush(idexe_flush_f),
        .fwd_a(fwd_a_f), .fwd_b(fwd_b_f), .state(state_f),
        .stall_cnt(stall_cnt_f), .flush_cnt(flush_cnt_f), .wait_cnt(wait_cnt_f)
    );

    pipeline_ctrl #(.LEN(32), .REG_W(REG_W), .FWD_EN(0), .CNT_W(CNT_W)) u_dut_nofwd (
        .clock(clock), .reset(reset),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_dest(ex_dest),
        .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .br_taken(br_taken),
        .pc_en(pc_en_n), .ifid_en(ifid_en_n), .idexe_en(idexe_en_n),
        .exemem_en(exemem_en_n), .memwb_en(memwb_en_n),
        .ifid_flush(ifid_flush_n), .idexe_flush(idexe_flush_n),
        .fwd_a(fwd_a_n), .fwd_b(fwd_b_n), .state(state_n),
        .stall_cnt(stall_cnt_n), .flush_cnt(flush_cnt_n), .wait_cnt(wait_cnt_n)
    );

    assign obs_f = {pc_en_f, ifid_en_f, idexe_en_f, exemem_en_f, memwb_en_f, ifid_flush_f,
                    idexe_flush_f, fwd_a_f, fwd_b_f, state_f, stall_cnt_f, flush_cnt_f, wait_cnt_f};
    assign obs_n = {pc_en_n, ifid_en_n, idexe_en_n, exemem_en_n, memwb_en_n, ifid_flush_n,
                    idexe_flush_n, fwd_a_n, fwd_b_n, state_n, stall_cnt_n, flush_cnt_n, wait_cnt_n};

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare(input string who, input obs_t a, input obs_t e);
        check({who, ".enables"},   48'(a.en), 48'(e.en));
        check({who, ".flushes"},   48'(a.fl), 48'(e.fl));
        check({who, ".fwd"},       48'({a.fa, a.fb}), 48'({e.fa, e.fb}));
        check({who, ".state"},     48'(a.st), 48'(e.st));
        check({who, ".stall_cnt"}, 48'(a.sc), 48'(e.sc));
        check({who, ".counters"},  48'({a.fc, a.wc}), 48'({e.fc, e.wc}));
    endtask

    // Monitor: outputs are valid every cycle; compare whenever an expectation is queued
    always @(negedge clock) begin
        if (sbq.size() > 0) begin
            mon_item = sbq.pop_front();
            compare("fwd_on",  obs_f, mon_item.e_fwd);
            compare("fwd_off", obs_n, mon_item.e_nofwd);
        end
    end

    function automatic bit id_reads(input logic [REG_W-1:0] r);
        if (r == 0) return 1'b0;
        return (r == id_src1) || (id_two_src && (r == id_src2));
    endfunction

    function automatic logic [1:0] exp_sel(input logic [REG_W-1:0] s);
        if (s == 0) return 2'd0;
        if (mem_wb_en && mem_dest == s) return 2'd1;
        if (wb_wb_en && wb_dest == s) return 2'd2;
        return 2'd0;
    endfunction

    function automatic int sat(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    // Expected outputs for the current inputs, then advance the model one clock
    task automatic model_step(input int f, output obs_t e);
        bit ms, hz;
        ms = mem_req && !mem_ready;
        hz = ex_mem_read && ex_wb_en && id_reads(ex_dest);
        if (f == 0) hz = hz || (ex_wb_en && id_reads(ex_dest)) || (mem_wb_en && id_reads(mem_dest));
        e = '0;
        if (reset) begin
            e.fl = 2'b11;
            m_wait[f] = 1'b0;
            m_sc[f] = 0; m_fc[f] = 0; m_wc[f] = 0;
        end else begin
            e.st = m_wait[f] && ms;
            e.sc = CNT_W'(m_sc[f]);
            e.fc = CNT_W'(m_fc[f]);
            e.wc = CNT_W'(m_wc[f]);
            if (f == 1) begin
                e.fa = exp_sel(ex_src1);
                e.fb = exp_sel(ex_src2);
            end
            if (ms) begin
                e.en = 5'b00000; e.fl = 2'b00;
                m_wc[f] = sat(m_wc[f]);
            end else if (br_taken) begin
                e.en = 5'b11111; e.fl = 2'b11;
                m_fc[f] = sat(m_fc[f]);
            end else if (hz) begin
                e.en = 5'b00111; e.fl = 2'b01;
                m_sc[f] = sat(m_sc[f]);
            end else begin
                e.en = 5'b11111; e.fl = 2'b00;
            end
            m_wait[f] = ms;
        end
    endtask

    // Called at posedge+1 with inputs already applied; ends at the next posedge+1
    task automatic run_cycle(input bit chk);
        exp_t x;
        model_step(1, x.e_fwd);
        model_step(0, x.e_nofwd);
        if (chk) sbq.push_back(x);
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0;
        id_src1 = '0; id_src2 = '0; id_two_src = 1'b0;
        ex_src1 = '0; ex_src2 = '0; ex_dest = '0; ex_wb_en = 1'b0; ex_mem_read = 1'b0;
        mem_dest = '0; mem_wb_en = 1'b0; mem_req = 1'b0; mem_ready = 1'b1;
        wb_dest = '0; wb_wb_en = 1'b0; br_taken = 1'b0;
    endtask

    task automatic rand_inputs();
        id_src1  = REG_W'($urandom_range(0, 7));
        id_src2  = REG_W'($urandom_range(0, 7));
        ex_src1  = REG_W'($urandom_range(0, 7));
        ex_src2  = REG_W'($urandom_range(0, 7));
        ex_dest  = REG_W'($urandom_range(0, 7));
        mem_dest = REG_W'($urandom_range(0, 7));
        wb_dest  = REG_W'($urandom_range(0, 7));
        id_two_src  = 1'($urandom_range(0, 1));
        ex_wb_en    = 1'($urandom_range(0, 1));
        ex_mem_read = ($urandom_range(0, 2) == 0);
        mem_wb_en   = 1'($urandom_range(0, 1));
        wb_wb_en    = 1'($urandom_range(0, 1));
        mem_req     = ($urandom_range(0, 2) == 0);
        mem_ready   = ($urandom_range(0, 2) != 0);
        br_taken    = ($urandom_range(0, 7) == 0);
    endtask

    task automatic set_load_use();
        ex_mem_read = 1'b1; ex_wb_en = 1'b1; ex_dest = REG_W'(5); id_src1 = REG_W'(5);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Reset holds outputs regardless of other inputs
        for (int i = 0; i < 3; i++) begin
            rand_inputs(); mem_req = 1'b1; mem_ready = 1'b0; reset = 1'b1;
            run_cycle(1'b1);
        end

        // Load-use: one bubble, stall_cnt 0 -> 1
        idle(); set_load_use(); run_cycle(1'b1);
        idle(); run_cycle(1'b1);

        // Forward priority MEM > WB > RF, register 0 never forwards
        idle(); mem_dest = REG_W'(3); wb_dest = REG_W'(3); ex_src1 = REG_W'(3);
        mem_wb_en = 1'b1; wb_wb_en = 1'b1; run_cycle(1'b1);
        mem_wb_en = 1'b0; run_cycle(1'b1);
        ex_src1 = '0; run_cycle(1'b1);

        // Memory wait of four cycles then release
        idle(); mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) run_cycle(1'b1);
        mem_ready = 1'b1; run_cycle(1'b1);
        idle(); run_cycle(1'b1);

        // Branch held through a three-cycle freeze, flushed on release
        idle(); mem_req = 1'b1; mem_ready = 1'b0; br_taken = 1'b1;
        for (int i = 0; i < 3; i++) run_cycle(1'b1);
        mem_ready = 1'b1; run_cycle(1'b1);
        idle(); run_cycle(1'b1);

        // Branch beats load-use; stall-only build stalls on a MEM producer of src2
        idle(); set_load_use(); br_taken = 1'b1; run_cycle(1'b1);
        idle(); id_two_src = 1'b1; id_src2 = REG_W'(7); mem_dest = REG_W'(7); mem_wb_en = 1'b1;
        run_cycle(1'b1);
        idle(); run_cycle(1'b1);

        // Random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            reset = ($urandom_range(0, 49) == 0);
            run_cycle(1'b1);
        end

        // stall_cnt saturation after 2^16+3 load-use stall cycles
        idle(); reset = 1'b1; run_cycle(1'b1);
        idle(); set_load_use();
        for (int i = 0; i < CNT_MAX + 4; i++) run_cycle((i % 8192 == 0) || (i > CNT_MAX - 4));
        idle(); run_cycle(1'b1);

        // Reset in MEM_WAIT aborts the wait
        idle(); mem_req = 1'b1; mem_ready = 1'b0;
        run_cycle(1'b1); run_cycle(1'b1);
        reset = 1'b1; run_cycle(1'b1);
        reset = 1'b0; run_cycle(1'b1);
        idle(); run_cycle(1'b1);

        check("scoreboard_drained", 48'(sbq.size()), 48'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
